// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment display scanner.
// Holds the FSM state encoding, the blank code and the width helpers.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         MAX_DIGITS = 8;

  // Anode vector with the low n bits set; every digit is dark when all ones.
  function automatic logic [MAX_DIGITS-1:0] anodes_off(input int n);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between the BCD datapath and the display scanner.
// The datapath side is the master; the scanner is the slave.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digitos;
  logic                    blank_leading;
  logic [3:0]              bcd_sel;
  logic [NUM_DIGITS-1:0]   anodos;
  logic                    frame_done;

  modport master (
    output enable, load, digitos, blank_leading,
    input  bcd_sel, anodos, frame_done
  );

  modport slave (
    input  enable, load, digitos, blank_leading,
    output bcd_sel, anodos, frame_done
  );
endinterface

// File: rtl/display_scan_controller_scan_slot_timer.sv
// Loadable down-counter timing one scan slot; tc_o is high while the count is zero.
// A slot of N cycles is obtained by loading N-1 on entry.
module scan_slot_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          tc_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes one external BCD-to-7-segment decoder over NUM_DIGITS
// common-anode digits, with optional blank gap and leading-zero suppression.
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GAP   = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  display_scan_controller_if.slave bus
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int TW = timer_width(REFRESH_DIV, BLANK_GAP);

  localparam bit                    HAS_GAP    = (BLANK_GAP > 0);
  localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0]         SHOW_LOAD  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0]         GAP_LOAD   = HAS_GAP ? TW'(BLANK_GAP - 1) : '0;
  localparam logic [MAX_DIGITS-1:0] OFF_FULL   = anodes_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = OFF_FULL[NUM_DIGITS-1:0];

  scan_state_e             state_q;
  logic [IW-1:0]           index_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [4*NUM_DIGITS-1:0] pending_q;
  logic                    pending_vld_q;
  logic                    frame_start_q;
  logic [NUM_DIGITS-1:0]   anodos_q;
  logic [3:0]              bcd_sel_q;
  logic                    frame_done_q;

  logic [NUM_DIGITS-1:0]   anodos_d;
  logic [3:0]              bcd_sel_d;
  logic                    frame_done_d;
  logic [IW-1:0]           index_next;
  logic                    index_wrap;
  logic [NUM_DIGITS-1:0]   lead_blank;
  logic                    upper_zero;
  logic [3:0]              sel_nib;
  logic                    sel_blank;

  logic                    tmr_clear;
  logic                    tmr_load;
  logic [TW-1:0]           tmr_load_val;
  logic                    tmr_tc;

  assign index_wrap = (index_q == LAST_IDX);
  assign index_next = index_wrap ? '0 : index_q + 1'b1;

  // Each slot length is armed on the cycle the previous slot ends.
  assign tmr_clear    = !bus.enable;
  assign tmr_load     = bus.enable && ((state_q == IDLE) || tmr_tc);
  assign tmr_load_val = ((state_q == SHOW) && HAS_GAP) ? GAP_LOAD : SHOW_LOAD;

  scan_slot_timer #(
    .TW(TW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .tc_o      (tmr_tc)
  );

  // A digit above zero is dark when it and every more significant digit are zero.
  always_comb begin
    lead_blank = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero && (shadow_q[4*i +: 4] == 4'h0);
      lead_blank[i] = (i != 0) && upper_zero;
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    anodos_d  = ANODES_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == index_q) begin
        sel_nib   = shadow_q[4*i +: 4];
        sel_blank = lead_blank[i];
      end
    end
    bcd_sel_d    = BCD_BLANK;
    frame_done_d = 1'b0;
    if (bus.enable && (state_q == SHOW)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == index_q) anodos_d[i] = 1'b0;
      end
      bcd_sel_d    = (bus.blank_leading && sel_blank) ? BCD_BLANK : sel_nib;
      frame_done_d = frame_start_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      index_q       <= '0;
      shadow_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      frame_start_q <= 1'b0;
      anodos_q      <= ANODES_OFF;
      bcd_sel_q     <= BCD_BLANK;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      anodos_q      <= anodos_d;
      bcd_sel_q     <= bcd_sel_d;
      frame_done_q  <= frame_done_d;
      case (state_q)
        IDLE: begin
          if (bus.load) shadow_q <= bus.digitos;
          if (bus.enable) begin
            state_q <= SHOW;
            index_q <= '0;
          end
        end
        SHOW: begin
          // A new value only reaches the shadow when the slot ends, so a lit digit never changes.
          if (!bus.enable || tmr_tc) begin
            if (bus.load) begin
              shadow_q <= bus.digitos;
            end else if (pending_vld_q) begin
              shadow_q <= pending_q;
            end
            pending_vld_q <= 1'b0;
            if (!bus.enable) begin
              state_q <= IDLE;
              index_q <= '0;
            end else if (HAS_GAP) begin
              state_q <= GAP;
            end else begin
              index_q       <= index_next;
              frame_start_q <= index_wrap;
            end
          end else if (bus.load) begin
            pending_q     <= bus.digitos;
            pending_vld_q <= 1'b1;
          end
        end
        GAP: begin
          if (bus.load) shadow_q <= bus.digitos;
          if (!bus.enable) begin
            state_q <= IDLE;
            index_q <= '0;
          end else if (tmr_tc) begin
            state_q       <= SHOW;
            index_q       <= index_next;
            frame_start_q <= index_wrap;
          end
        end
        default: begin
          state_q <= IDLE;
          index_q <= '0;
        end
      endcase
    end
  end

  assign bus.anodos     = anodos_q;
  assign bus.bcd_sel    = bcd_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with 4 digits, 4-cycle slots, 1-cycle gap.
// Observed word is {frame_done, anodos[3:0], bcd_sel[3:0]}.
module tb_display_scan_controller;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  display_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  display_scan_controller #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .BLANK_GAP  (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [8:0] BLANK_W = {1'b0, 4'hF, 4'hF};

  function automatic logic [8:0] obs();
    return {bus.frame_done, bus.anodos, bus.bcd_sel};
  endfunction

  // Expected word at cycle k of a frame whose first lit cycle is k=0; k=20 starts the next frame.
  function automatic logic [8:0] frame_exp(input int k, input logic [15:0] bcds);
    int         slot;
    logic [3:0] an;
    if (k >= 20) return {1'b1, 4'b1110, bcds[3:0]};
    slot = k / 5;
    if ((k % 5) == 4) return BLANK_W;
    an       = 4'hF;
    an[slot] = 1'b0;
    return {1'b0, an, bcds[slot*4 +: 4]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] bcds, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      check($sformatf("%s_k%0d", tag, k), obs(), frame_exp(k, bcds));
      if (k < k1) tick();
    end
  endtask

  // Park in IDLE while loading, then enable; leaves the bench at the first lit cycle.
  task automatic start_scan(input string tag, input logic [15:0] v, input logic bl);
    bus.enable        = 1'b0;
    bus.load          = 1'b1;
    bus.digitos       = v;
    bus.blank_leading = bl;
    tick();
    check({tag, "_off"}, obs(), BLANK_W);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check({tag, "_lat"}, obs(), BLANK_W);
    tick();
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    rst_n             = 1'b1;
    bus.enable        = 1'b0;
    bus.load          = 1'b0;
    bus.digitos       = '0;
    bus.blank_leading = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset", obs(), BLANK_W);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle", obs(), BLANK_W);

    // Plain scan of 1234 and frame_done on the wrap.
    start_scan("t1", 16'h1234, 1'b0);
    run_frame("t1", 16'h1234, 0, 20);
    tick();
    check("t1_fd_once", obs(), {1'b0, 4'b1110, 4'h4});

    // Leading-zero suppression on and off.
    start_scan("t2b", 16'h0070, 1'b1);
    run_frame("t2b", 16'hFF70, 0, 20);
    start_scan("t2n", 16'h0070, 1'b0);
    run_frame("t2n", 16'h0070, 0, 20);

    // All zero: only digit 0 shows a figure.
    start_scan("t3", 16'h0000, 1'b1);
    run_frame("t3", 16'hFFF0, 0, 20);

    // Load inside the digit-1 slot is held back until the slot ends.
    start_scan("t4", 16'h1234, 1'b0);
    run_frame("t4", 16'h1234, 0, 5);
    bus.load    = 1'b1;
    bus.digitos = 16'h5678;
    tick();
    bus.load    = 1'b0;
    bus.digitos = 16'h0000;
    run_frame("t4", 16'h5638, 6, 20);

    // Enable dropped during digit 2, then restart with shadow kept.
    tick();
    run_frame("t5a", 16'h5678, 1, 11);
    bus.enable = 1'b0;
    tick();
    check("t5_drop", obs(), BLANK_W);
    tick();
    check("t5_idle", obs(), BLANK_W);
    bus.enable = 1'b1;
    tick();
    check("t5_lat", obs(), BLANK_W);
    tick();
    run_frame("t5b", 16'h5678, 0, 20);

    // Asynchronous reset while frame_done is high.
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", obs(), BLANK_W);
    #2 rst_n = 1'b1;
    tick();
    check("t6_lat", obs(), BLANK_W);
    tick();
    check("t6_d0", obs(), {1'b0, 4'b1110, 4'h0});
    tick();
    check("t6_d0b", obs(), {1'b0, 4'b1110, 4'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
